// File: rtl/weight_mem_pkg.sv
// Shared constants for the weight RAM write path: byte width and FSM state encoding.
package weight_mem_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/weight_mem_writer_byte_packer.sv
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
// word_next is the word including the byte being pushed, so a full or final word can be latched on that same edge.
module byte_packer
  import weight_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  last,
  input  logic [BYTE_W-1:0]     data,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_full
);

  localparam int LANES = DATA_WIDTH / BYTE_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0]         lane;
  logic [DATA_WIDTH-1:0] word_q;

  always_comb begin
    word_next = word_q;
    word_next[lane*BYTE_W +: BYTE_W] = data;
  end

  assign word_full = push && (lane == LW'(LANES - 1));

  // Register is zeroed after every emitted word so a flushed partial word has zero upper lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane   <= '0;
      word_q <= '0;
    end else if (clr) begin
      lane   <= '0;
      word_q <= '0;
    end else if (push) begin
      if (word_full || last) begin
        lane   <= '0;
        word_q <= '0;
      end else begin
        lane   <= lane + 1'b1;
        word_q <= word_next;
      end
    end
  end

endmodule

// File: rtl/weight_mem_writer.sv
// Streams int8 weight bytes into a weight RAM, one packed word per address starting at 0.
//   state | meaning
//   IDLE  | waiting for start after reset
//   LOAD  | accepting bytes, writing each completed word
//   FLUSH | writing the zero-padded final partial word
//   DONE  | load complete; count and overflow held until next start
module weight_mem_writer
  import weight_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_full;
  logic                  accept;
  logic                  mem_full;
  logic                  write_fire;
  logic                  load_entry;

  assign in_ready   = (state == LOAD);
  assign accept     = in_valid && (state == LOAD);
  assign mem_full   = (word_count == DEPTH);
  assign write_fire = accept && !mem_full && (word_full || in_last);
  assign load_entry = start && ((state == IDLE) || (state == DONE));

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (load_entry),
    .push      (accept),
    .last      (in_last),
    .data      (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        // Once memory is full the last byte has nothing left to flush.
        if (accept && in_last) state_nxt = (word_full || mem_full) ? DONE : FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      addr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      mem_en <= write_fire;
      if (load_entry) begin
        addr       <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (write_fire) begin
          mem_addr   <= addr;
          mem_data   <= word_next;
          addr       <= addr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        if (accept && mem_full) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/weight_mem_writer.md
Name: weight_mem_writer

Overview:
Write-side counterpart of the weight ROM. Accepts a valid/ready stream of int8 weight bytes, packs them little-endian into DATA_WIDTH-bit words and issues one synchronous write per word to a weight RAM at consecutive addresses. The RAM is later read by the compute cells exactly as the ROM is read: one word per address, same address and data geometry.

Parameters:
ADDR_WIDTH, 4, weight memory address width; depth is 2**ADDR_WIDTH words
DATA_WIDTH, 32, memory word width; must be a multiple of 8
LANES, DATA_WIDTH/8, bytes per word (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load at address 0 (ignored unless IDLE or DONE)
in_valid  in  1  byte stream valid
in_ready  out  1  byte stream ready
in_data  in  8  int8 weight byte
in_last  in  1  marks final byte of the load
mem_en  out  1  memory write enable, one cycle per word
mem_addr  out  ADDR_WIDTH  write address
mem_data  out  DATA_WIDTH  packed write word
busy  out  1  high in LOAD and FLUSH
done  out  1  high in DONE until next start
overflow  out  1  sticky; set if bytes arrive after the last address was written
word_count  out  ADDR_WIDTH+1  words written in the current load

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; lane index, address and partial word cleared. Reset mid-load discards the partial word; no write is issued.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE + start -> LOAD. On entry: addr=0, lane=0, word_count=0, overflow=0, done=0.
- LOAD: in_ready=1. A byte is accepted when in_valid&in_ready. Byte k of a word goes to bits [8k+7:8k] (first byte in LSBs).
- When lane LANES-1 is accepted: the next cycle has mem_en=1, mem_addr=current addr and mem_data=the full word (one-cycle registered latency). Then addr+1, lane=0, word_count+1.
- in_last on a byte that completes a word: write as above, then DONE.
- in_last on a partial word: go to FLUSH. Unfilled lanes are zero. The write is issued the next cycle, then DONE.
- in_ready=0 in FLUSH, DONE and IDLE.
- Address wrap: after writing addr 2**ADDR_WIDTH-1, further bytes are still accepted (stream is not stalled) but dropped. overflow=1 (sticky), no mem_en, word_count saturates at 2**ADDR_WIDTH. in_last still ends the load in DONE.
- start while busy: ignored.
- start and in_valid in the same IDLE cycle: the byte is not accepted (in_ready=0).
- mem_en is never asserted outside the single write cycle; mem_addr and mem_data hold their last value otherwise.
- DONE: done=1, busy=0; word_count and overflow hold until the next start.

Decomposition:
- Shared package weight_mem_pkg: constant BYTE_W=8 and state encoding localparams (IDLE=0, LOAD=1, FLUSH=2, DONE=3).
- One sub-module, byte_packer. It holds the lane counter and shift/insert register and signals word_full. The top holds the FSM, address counter and overflow logic.

Test Plan:
- Reset then start; stream 8 bytes 0x01..0x08 with last on 0x08 -> writes addr0=0x04030201, addr1=0x08070605; done=1; word_count=2.
- Stream 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE with last on 0xEE -> addr0=0xDDCCBBAA, addr1=0x000000EE (flush); word_count=2.
- Stream 68 bytes (17 words) into the 16-word memory -> 16 writes (addr 0..15), no write for word 17; overflow=1; word_count=16; done=1.
- Drop rst_n after 3 bytes of a word -> all outputs 0 immediately; no mem_en; a following start+4 bytes -> addr0 holds only the new bytes.
- Toggle in_valid every other cycle and pulse start mid-load -> packing unaffected, start ignored; write appears exactly one cycle after the 4th accepted byte.
